vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator producing horizontal/vertical sync, an active-video flag, pixel coordinates and line/frame start strobes from a single system clock gated by a pixel clock enable. It replaces fixed-porch sync generation: every timing segment (active, front porch, sync, back porch) and each sync polarity is set by a parameter. It sits between the clock-enable divider and the pixel pattern/framebuffer logic, which consumes `o_Col`, `o_Row` and `o_Active`.

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_axis_counter.sv | 85 ++++++++
 rtl/vga_timing_gen.sv | 79 +++++++
 tb/tb_vga_timing_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared constants for the VGA timing generator.
// Default 640x480@60 segments, polarity codes and a segment-sum helper.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned CNT_WIDTH = 10;

  localparam logic POL_LOW  = 1'b0;
  localparam logic POL_HIGH = 1'b1;

  function automatic int unsigned total(
    input int unsigned active,
    input int unsigned front,
    input int unsigned sync,
    input int unsigned back
  );
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (column or row) with sync/active decode.
// Ports: clk, rst_n, advance in; value, wrap pulse, sync, active, next_wrap out.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned P_ACTIVE = H_ACTIVE,
  parameter int unsigned P_FRONT  = H_FRONT,
  parameter int unsigned P_SYNC   = H_SYNC,
  parameter int unsigned P_BACK   = H_BACK,
  parameter logic        P_POL    = POL_LOW,
  parameter int unsigned P_WIDTH  = CNT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               advance,
  output logic [P_WIDTH-1:0] value,
  output logic               wrap,
  output logic               sync,
  output logic               active,
  output logic               next_wrap
);

  localparam int unsigned TOTAL =
    total(P_ACTIVE, P_FRONT, P_SYNC, P_BACK);

  if (P_ACTIVE == 0 || P_FRONT == 0 ||
      P_SYNC == 0 || P_BACK == 0) begin : g_seg_err
    $error("vga_axis_counter: zero-width segment");
  end

  if (64'(TOTAL) > (64'd1 << P_WIDTH)) begin : g_wid_err
    $error("vga_axis_counter: counter too narrow");
  end

  localparam logic [P_WIDTH-1:0] LAST =
    P_WIDTH'(TOTAL - 1);
  localparam logic [P_WIDTH-1:0] SYNC_LO =
    P_WIDTH'(P_ACTIVE + P_FRONT);
  localparam logic [P_WIDTH-1:0] SYNC_HI =
    P_WIDTH'(P_ACTIVE + P_FRONT + P_SYNC - 1);
  localparam logic [P_WIDTH-1:0] ACT_END =
    P_WIDTH'(P_ACTIVE);

  logic [P_WIDTH-1:0] value_q, value_d;
  logic wrap_q, wrap_d;
  logic sync_q, sync_d;
  logic active_q, active_d;

  assign next_wrap = (value_q == LAST);

  // Decode uses the next count so flags line up with value.
  always_comb begin
    value_d  = value_q;
    wrap_d   = 1'b0;
    sync_d   = sync_q;
    active_d = active_q;
    if (advance) begin
      value_d  = next_wrap ? '0 : value_q + P_WIDTH'(1);
      wrap_d   = next_wrap;
      sync_d   = (value_d >= SYNC_LO && value_d <= SYNC_HI)
                 ? P_POL : ~P_POL;
      active_d = (value_d < ACT_END);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q  <= LAST;
      wrap_q   <= 1'b0;
      sync_q   <= ~P_POL;
      active_q <= 1'b0;
    end else begin
      value_q  <= value_d;
      wrap_q   <= wrap_d;
      sync_q   <= sync_d;
      active_q <= active_d;
    end
  end

  assign value  = value_q;
  assign wrap   = wrap_q;
  assign sync   = sync_q;
  assign active = active_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing (syncs, active, coords).
// Ports: i_Clk, i_Rst_n, i_Ce in; syncs, active, col/row, line/frame strobes out.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned g_Active_Col = H_ACTIVE,
  parameter int unsigned g_Front_Col  = H_FRONT,
  parameter int unsigned g_Sync_Col   = H_SYNC,
  parameter int unsigned g_Back_Col   = H_BACK,
  parameter int unsigned g_Active_Row = V_ACTIVE,
  parameter int unsigned g_Front_Row  = V_FRONT,
  parameter int unsigned g_Sync_Row   = V_SYNC,
  parameter int unsigned g_Back_Row   = V_BACK,
  parameter logic        g_HSync_Pol  = POL_LOW,
  parameter logic        g_VSync_Pol  = POL_LOW,
  parameter int unsigned g_Cnt_Width  = CNT_WIDTH
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic                   i_Ce,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic                   o_Active,
  output logic [g_Cnt_Width-1:0] o_Col,
  output logic [g_Cnt_Width-1:0] o_Row,
  output logic                   o_Line_Start,
  output logic                   o_Frame_Start
);

  logic h_wrap, h_active, h_next_wrap;
  logic v_wrap, v_active;
  logic v_adv;
  logic unused_v_next_wrap;

  // Rows step only on the enabled cycle that wraps the column.
  assign v_adv = i_Ce & h_next_wrap;

  vga_axis_counter #(
    .P_ACTIVE (g_Active_Col),
    .P_FRONT  (g_Front_Col),
    .P_SYNC   (g_Sync_Col),
    .P_BACK   (g_Back_Col),
    .P_POL    (g_HSync_Pol),
    .P_WIDTH  (g_Cnt_Width)
  ) u_h (
    .clk       (i_Clk),
    .rst_n     (i_Rst_n),
    .advance   (i_Ce),
    .value     (o_Col),
    .wrap      (h_wrap),
    .sync      (o_HSync),
    .active    (h_active),
    .next_wrap (h_next_wrap)
  );

  vga_axis_counter #(
    .P_ACTIVE (g_Active_Row),
    .P_FRONT  (g_Front_Row),
    .P_SYNC   (g_Sync_Row),
    .P_BACK   (g_Back_Row),
    .P_POL    (g_VSync_Pol),
    .P_WIDTH  (g_Cnt_Width)
  ) u_v (
    .clk       (i_Clk),
    .rst_n     (i_Rst_n),
    .advance   (v_adv),
    .value     (o_Row),
    .wrap      (v_wrap),
    .sync      (o_VSync),
    .active    (v_active),
    .next_wrap (unused_v_next_wrap)
  );

  // Row wrap pulse can only occur together with a column wrap.
  assign o_Active      = h_active & v_active;
  assign o_Line_Start  = h_wrap;
  assign o_Frame_Start = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for three generator configurations.
// Default low-pol, default high-pol and a tiny 7x6 raster share ce/reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ce, rst_n;

  logic       hs0, vs0, a0, ls0, fs0;
  logic [9:0] c0, r0;
  logic       hs1, vs1, a1, ls1, fs1;
  logic [9:0] c1, r1;
  logic       hs2, vs2, a2, ls2, fs2;
  logic [3:0] c2, r2;

  vga_timing_gen dut0 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Ce(ce),
    .o_HSync(hs0), .o_VSync(vs0), .o_Active(a0),
    .o_Col(c0), .o_Row(r0),
    .o_Line_Start(ls0), .o_Frame_Start(fs0)
  );

  vga_timing_gen #(
    .g_HSync_Pol(1'b1), .g_VSync_Pol(1'b1)
  ) dut1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Ce(ce),
    .o_HSync(hs1), .o_VSync(vs1), .o_Active(a1),
    .o_Col(c1), .o_Row(r1),
    .o_Line_Start(ls1), .o_Frame_Start(fs1)
  );

  vga_timing_gen #(
    .g_Active_Col(4), .g_Front_Col(1),
    .g_Sync_Col(1), .g_Back_Col(1),
    .g_Active_Row(3), .g_Front_Row(1),
    .g_Sync_Row(1), .g_Back_Row(1),
    .g_Cnt_Width(4)
  ) dut2 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Ce(ce),
    .o_HSync(hs2), .o_VSync(vs2), .o_Active(a2),
    .o_Col(c2), .o_Row(r2),
    .o_Line_Start(ls2), .o_Frame_Start(fs2)
  );

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic hs, vs, act, ls, fs;
  } exp_t;
  typedef exp_t [2:0] vec_t;

  vec_t sbq[$];
  vec_t act_v;

  assign act_v[0] = {c0, r0, hs0, vs0, a0, ls0, fs0};
  assign act_v[1] = {c1, r1, hs1, vs1, a1, ls1, fs1};
  assign act_v[2] = {6'd0, c2, 6'd0, r2,
                     hs2, vs2, a2, ls2, fs2};

  localparam int HA[3] = '{640, 640, 4};
  localparam int HF[3] = '{16, 16, 1};
  localparam int HS[3] = '{96, 96, 1};
  localparam int HB[3] = '{48, 48, 1};
  localparam int VA[3] = '{480, 480, 3};
  localparam int VF[3] = '{10, 10, 1};
  localparam int VS[3] = '{2, 2, 1};
  localparam int VB[3] = '{33, 33, 1};
  localparam int HP[3] = '{0, 1, 0};
  localparam int VP[3] = '{0, 1, 0};

  int mc[3], mr[3];
  bit mhs[3], mvs[3], mact[3], mls[3], mfs[3];

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s actual=%0d expected=%0d",
                 nm, a, e);
    end
  endtask

  task automatic model(input logic c, input logic r);
    for (int k = 0; k < 3; k++) begin
      int ht, vt;
      bit hw, vw;
      ht = HA[k] + HF[k] + HS[k] + HB[k];
      vt = VA[k] + VF[k] + VS[k] + VB[k];
      if (!r) begin
        mc[k] = ht - 1;
        mr[k] = vt - 1;
        mls[k] = 0;
        mfs[k] = 0;
        mhs[k] = (HP[k] == 0);
        mvs[k] = (VP[k] == 0);
        mact[k] = 0;
      end else if (c) begin
        mls[k] = 0;
        mfs[k] = 0;
        if (mc[k] == ht - 1) begin
          mc[k] = 0;
          mls[k] = 1;
          if (mr[k] == vt - 1) begin
            mr[k] = 0;
            mfs[k] = 1;
          end else begin
            mr[k]++;
          end
        end else begin
          mc[k]++;
        end
        hw = mc[k] >= HA[k] + HF[k] &&
             mc[k] < HA[k] + HF[k] + HS[k];
        vw = mr[k] >= VA[k] + VF[k] &&
             mr[k] < VA[k] + VF[k] + VS[k];
        mhs[k] = hw ? (HP[k] != 0) : (HP[k] == 0);
        mvs[k] = vw ? (VP[k] != 0) : (VP[k] == 0);
        mact[k] = mc[k] < HA[k] && mr[k] < VA[k];
      end else begin
        mls[k] = 0;
        mfs[k] = 0;
      end
    end
  endtask

  task automatic step(input logic c, input logic r);
    vec_t v;
    @(negedge clk);
    ce = c;
    rst_n = r;
    @(posedge clk);
    model(c, r);
    for (int k = 0; k < 3; k++)
      v[k] = {10'(mc[k]), 10'(mr[k]), mhs[k],
              mvs[k], mact[k], mls[k], mfs[k]};
    sbq.push_back(v);
    #1;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      vec_t e;
      e = sbq.pop_front();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("sb%0d.col", k),
            32'(act_v[k].col), 32'(e[k].col));
        chk($sformatf("sb%0d.row", k),
            32'(act_v[k].row), 32'(e[k].row));
        chk($sformatf("sb%0d.hs", k),
            32'(act_v[k].hs), 32'(e[k].hs));
        chk($sformatf("sb%0d.vs", k),
            32'(act_v[k].vs), 32'(e[k].vs));
        chk($sformatf("sb%0d.act", k),
            32'(act_v[k].act), 32'(e[k].act));
        chk($sformatf("sb%0d.ls", k),
            32'(act_v[k].ls), 32'(e[k].ls));
        chk($sformatf("sb%0d.fs", k),
            32'(act_v[k].fs), 32'(e[k].fs));
      end
    end
  end

  int hs_low, hs_first, hs_last, act_cnt;
  int hs1_hi, ls_cnt, ls_at, nfs2, fs2_last;
  int tiny_act, strobe_bad, fs2c, fs2c_last, ls0c;

  initial begin
    ce = 1'b0;
    rst_n = 1'b0;
    hs_low = 0; hs_first = -1; hs_last = -1;
    act_cnt = 0; hs1_hi = 0; ls_cnt = 0;
    ls_at = -1; nfs2 = 0; fs2_last = 0;
    tiny_act = 0; strobe_bad = 0;
    fs2c = 0; fs2c_last = 0; ls0c = 0;

    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("rst.col", 32'(c0), 799);
    chk("rst.row", 32'(r0), 524);
    chk("rst.hs", 32'(hs0), 1);
    chk("rst.vs", 32'(vs0), 1);
    chk("rst.act", 32'(a0), 0);
    chk("rst.ls", 32'(ls0), 0);
    chk("rst.fs", 32'(fs0), 0);
    chk("rst.hs_hi", 32'(hs1), 0);
    chk("rst.vs_hi", 32'(vs1), 0);
    chk("rst.tiny_col", 32'(c2), 6);
    chk("rst.tiny_row", 32'(r2), 5);

    step(1'b1, 1'b1);
    chk("first.col", 32'(c0), 0);
    chk("first.row", 32'(r0), 0);
    chk("first.act", 32'(a0), 1);
    chk("first.ls", 32'(ls0), 1);
    chk("first.fs", 32'(fs0), 1);
    chk("first.tiny_fs", 32'(fs2), 1);

    step(1'b0, 1'b1);
    chk("stall.col", 32'(c0), 0);
    chk("stall.ls", 32'(ls0), 0);
    chk("stall.fs", 32'(fs0), 0);

    for (int i = 1; i < 1600; i++) begin
      step(1'b1, 1'b1);
      if (i >= 800) begin
        if (!hs0) begin
          hs_low++;
          if (hs_first < 0) hs_first = int'(c0);
          hs_last = int'(c0);
        end
        if (a0) act_cnt++;
        if (hs1) hs1_hi++;
      end
      if (ls0) begin
        ls_cnt++;
        ls_at = i;
      end
      if (fs2) begin
        nfs2++;
        if (nfs2 <= 3)
          chk("tiny.fs_gap", 32'(i - fs2_last), 42);
        fs2_last = i;
      end
      if (i >= 42 && i < 84 && a2) tiny_act++;
    end
    chk("line.hs_low", 32'(hs_low), 96);
    chk("line.hs_first", 32'(hs_first), 656);
    chk("line.hs_last", 32'(hs_last), 751);
    chk("line.act", 32'(act_cnt), 640);
    chk("line.hs_hi_pol", 32'(hs1_hi), 96);
    chk("line.ls_cnt", 32'(ls_cnt), 1);
    chk("line.ls_at", 32'(ls_at), 800);
    chk("tiny.act", 32'(tiny_act), 12);
    chk("tiny.fs_cnt", 32'(nfs2), 38);

    for (int j = 0; j < 3200; j++) begin
      step((j % 4) == 0, 1'b1);
      if ((j % 4) != 0 && (ls0 || fs2 || ls2))
        strobe_bad++;
      if (ls0) ls0c++;
      if (fs2) begin
        if (fs2c > 0)
          chk("ce4.fs_clk_gap", 32'(j - fs2c_last), 168);
        fs2c_last = j;
        fs2c++;
      end
    end
    chk("ce4.strobe_stall", 32'(strobe_bad), 0);
    chk("ce4.ls_cnt", 32'(ls0c), 1);
    chk("ce4.tiny_fs_cnt", 32'(fs2c), 19);

    for (int i = 0; i < 701; i++) step(1'b1, 1'b1);
    chk("mid.col", 32'(c0), 700);
    chk("mid.row", 32'(r0), 3);
    chk("mid.hs", 32'(hs0), 0);

    step(1'b1, 1'b0);
    chk("midrst.col", 32'(c0), 799);
    chk("midrst.row", 32'(r0), 524);
    chk("midrst.hs", 32'(hs0), 1);
    chk("midrst.act", 32'(a0), 0);
    chk("midrst.ls", 32'(ls0), 0);

    step(1'b0, 1'b1);
    chk("rel.col", 32'(c0), 799);
    chk("rel.fs", 32'(fs0), 0);

    step(1'b1, 1'b1);
    chk("rel.ce_col", 32'(c0), 0);
    chk("rel.ce_row", 32'(r0), 0);
    chk("rel.ce_fs", 32'(fs0), 1);
    chk("rel.ce_ls", 32'(ls0), 1);

    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    @(negedge clk);
    #1;
    chk("sb.drained", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
